// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared definitions for the data-memory responder: FSM state encoding,
//   wait-counter width and the address alignment mask used by the error check.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Wide enough for LATENCY-1 with LATENCY up to 15
   localparam int LAT_W = 4;

   // Word accesses only: any low address bit set is a misaligned request
   localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bus between a memory-stage initiator and the responder.
//   master : initiator side (drives request fields and rsp_ready)
//   slave  : responder side (drives req_ready and response fields)
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array
//   DEPTH x 32-bit word storage. Synchronous write, asynchronous read.
//   Contents are not reset.
//   o_rdata : word at i_addr (combinational)
//   i_addr  : word index
//   i_wdata : write data
//   i_we    : write enable, sampled on rising i_clk
//   i_clk   : clock
module dmem_array #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   output logic [31:0]   o_rdata,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   input  logic          i_we,
   input  logic          i_clk
);

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Target-side data memory with configurable response latency. Accepts one
//   request at a time, waits LATENCY cycles, commits the store or reads the
//   word, then holds the response until the initiator takes it.
//   clk : rising-edge clock
//   rst : asynchronous reset, active-high
//   bus : request/response handshake (slave side)
//   Parameters: DEPTH words of storage, LATENCY wait cycles (0..15),
//   BASE byte address of word 0.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          DEPTH   = 256,
   parameter int          LATENCY = 2,
   parameter logic [31:0] BASE    = 32'h0000_0000
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [LAT_W-1:0] LAT_INIT =
      (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

   state_t           r_state, w_next;
   logic [LAT_W-1:0] r_cnt;
   logic             r_we;
   logic [31:0]      r_addr, r_wdata;
   logic [31:0]      r_rdata;
   logic             r_err;

   logic             w_accept, w_commit;
   logic             w_c_we, w_c_err, w_mem_we;
   logic [31:0]      w_c_addr, w_c_wdata, w_off, w_mem_rdata;
   logic [IDX_W-1:0] w_idx;

   assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

   // With no wait cycles the commit happens at the accept edge itself, so it
   // must work from the live bus fields rather than the capture registers.
   generate
      if (LATENCY == 0) begin : g_lat0
         assign w_commit  = w_accept;
         assign w_c_we    = bus.req_we;
         assign w_c_addr  = bus.req_addr;
         assign w_c_wdata = bus.req_wdata;
      end else begin : g_latn
         assign w_commit  = (r_state == ST_WAIT) && (r_cnt == '0);
         assign w_c_we    = r_we;
         assign w_c_addr  = r_addr;
         assign w_c_wdata = r_wdata;
      end
   endgenerate

   // Offset wraps modulo 2^32, so addresses below BASE land far out of range
   assign w_off   = w_c_addr - BASE;
   assign w_idx   = IDX_W'(w_off >> 2);
   assign w_c_err = (|(w_c_addr[1:0] & ALIGN_MASK)) ||
                    ((w_off >> 2) >= 32'(DEPTH));

   // rst gate keeps a zero-latency accept from writing while reset is held
   assign w_mem_we = w_commit && w_c_we && !w_c_err && !rst;

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .o_rdata (w_mem_rdata),
      .i_addr  (w_idx),
      .i_wdata (w_c_wdata),
      .i_we    (w_mem_we),
      .i_clk   (clk)
   );

   always_comb begin
      w_next        = r_state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = r_rdata;
      bus.rsp_err   = r_err;
      case (r_state)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) w_next = (LATENCY == 0) ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            if (r_cnt == '0) w_next = ST_RESP;
         end
         ST_RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= LAT_INIT;
         end else if (r_state == ST_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_commit) begin
            r_err   <= w_c_err;
            r_rdata <= (w_c_we || w_c_err) ? '0 : w_mem_rdata;
         end else if (r_state == ST_RESP && bus.rsp_ready) begin
            r_err   <= 1'b0;
            r_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int          D2 = 256;
   localparam logic [31:0] B2 = 32'h0000_0000;
   localparam int          D0 = 64;
   localparam logic [31:0] B0 = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_responder_if if2();
   dmem_responder_if if0();

   dmem_responder #(.DEPTH(D2), .LATENCY(2), .BASE(B2)) u_lat2 (
      .clk(clk), .rst(rst), .bus(if2));
   dmem_responder #(.DEPTH(D0), .LATENCY(0), .BASE(B0)) u_lat0 (
      .clk(clk), .rst(rst), .bus(if0));

   // shared drive, steered to one DUT by sel
   bit          sel = 1'b0;
   logic        d_valid = 1'b0, d_we = 1'b0, d_rrdy = 1'b0;
   logic [31:0] d_addr = '0, d_wdata = '0;

   assign if2.req_valid = d_valid & ~sel;
   assign if0.req_valid = d_valid &  sel;
   assign if2.req_we    = d_we;    assign if0.req_we    = d_we;
   assign if2.req_addr  = d_addr;  assign if0.req_addr  = d_addr;
   assign if2.req_wdata = d_wdata; assign if0.req_wdata = d_wdata;
   assign if2.rsp_ready = d_rrdy & ~sel;
   assign if0.rsp_ready = d_rrdy &  sel;

   logic        rv, rdy, er;
   logic [31:0] rd;
   assign rv  = sel ? if0.rsp_valid : if2.rsp_valid;
   assign rdy = sel ? if0.req_ready : if2.req_ready;
   assign er  = sel ? if0.rsp_err   : if2.rsp_err;
   assign rd  = sel ? if0.rsp_rdata : if2.rsp_rdata;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0;

   // reference storage: value plus "has been written" flag per word
   logic [31:0] mdl [0:1][0:255];
   bit          kn  [0:1][0:255];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_err(input bit s, input logic [31:0] a);
      logic [31:0] off;
      off = a - (s ? B0 : B2);
      return (a[1:0] != 2'b00) || ((off >> 2) >= 32'(s ? D0 : D2));
   endfunction

   // Runs one request; must be entered at a negedge with the DUT idle and
   // returns at a negedge with the DUT idle again.
   task automatic xact(input bit s, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, output int acc);
      int          lat, idx;
      bit          e, rd_known;
      logic [31:0] exp_rd, off, rd0;
      lat = s ? 0 : 2;
      e   = exp_err(s, a);
      off = a - (s ? B0 : B2);
      idx = int'(off >> 2);
      exp_rd = 32'h0;
      rd_known = 1'b1;
      if (!we && !e) begin
         rd_known = kn[s][idx];
         exp_rd   = mdl[s][idx];
      end
      sel = s;
      #0;
      chk("req_ready_idle", {31'b0, rdy}, 32'd1);
      d_valid = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_rrdy = 1'b0;
      @(posedge clk);
      #1;
      acc = cyc;
      // scramble inputs after accept: only captured values may matter
      d_valid = 1'b0; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         chk("wait_rsp_valid", {31'b0, rv}, 32'd0);
         chk("wait_req_ready", {31'b0, rdy}, 32'd0);
      end
      @(negedge clk);
      chk("rsp_valid", {31'b0, rv}, 32'd1);
      chk("rsp_err", {31'b0, er}, {31'b0, e});
      if (rd_known) chk("rsp_rdata", rd, exp_rd);
      rd0 = rd_known ? exp_rd : rd;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("bp_rsp_valid", {31'b0, rv}, 32'd1);
         chk("bp_req_ready", {31'b0, rdy}, 32'd0);
         chk("bp_rsp_err", {31'b0, er}, {31'b0, e});
         chk("bp_rsp_rdata", rd, rd0);
      end
      d_rrdy = 1'b1;
      @(negedge clk);
      chk("post_rsp_valid", {31'b0, rv}, 32'd0);
      chk("post_req_ready", {31'b0, rdy}, 32'd1);
      d_rrdy = 1'b0;
      if (we && !e) begin
         mdl[s][idx] = wd;
         kn[s][idx]  = 1'b1;
      end
   endtask

   initial begin
      int a0, a1, a2, acc;
      bit s, we;
      logic [31:0] addr;
      for (int i = 0; i < 256; i++) begin
         kn[0][i] = 1'b0; kn[1][i] = 1'b0; mdl[0][i] = '0; mdl[1][i] = '0;
      end

      // reset state of both instances
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid2", {31'b0, if2.rsp_valid}, 32'd0);
      chk("rst_req_ready2", {31'b0, if2.req_ready}, 32'd1);
      chk("rst_rsp_rdata2", if2.rsp_rdata, 32'd0);
      chk("rst_rsp_err2",   {31'b0, if2.rsp_err}, 32'd0);
      chk("rst_rsp_valid0", {31'b0, if0.rsp_valid}, 32'd0);
      chk("rst_req_ready0", {31'b0, if0.req_ready}, 32'd1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_no_rsp", {31'b0, if2.rsp_valid}, 32'd0);
      end

      // store then load, back-pressure, errors (LATENCY=2)
      xact(0, 1, 32'h10, 32'hDEADBEEF, 0, acc);
      xact(0, 0, 32'h10, 32'h0, 0, acc);
      xact(0, 0, 32'h10, 32'h0, 5, acc);
      xact(0, 0, 32'h13, 32'h0, 0, acc);
      xact(0, 1, 32'h0, 32'hA5A50001, 0, acc);
      xact(0, 1, 32'h400, 32'hBAD0BAD0, 2, acc);
      xact(0, 0, 32'h0, 32'h0, 0, acc);
      xact(0, 0, 32'h3FC, 32'h0, 0, acc);

      // reset in the middle of a store's wait
      xact(0, 1, 32'h20, 32'hCAFEF00D, 0, acc);
      d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234;
      @(posedge clk);
      #1 d_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rsp_valid", {31'b0, rv}, 32'd0);
      chk("mid_rst_req_ready", {31'b0, rdy}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("after_rst_no_rsp", {31'b0, rv}, 32'd0);
      end
      xact(0, 0, 32'h20, 32'h0, 0, acc);

      // LATENCY=0: fill, boundary errors, then back-to-back loads
      xact(1, 1, B0 + 32'h0, 32'h11111111, 0, acc);
      xact(1, 1, B0 + 32'h4, 32'h22222222, 0, acc);
      xact(1, 1, B0 + 32'h8, 32'h33333333, 0, acc);
      xact(1, 0, B0 - 32'h4, 32'h0, 0, acc);
      xact(1, 1, B0 + 32'(D0 * 4), 32'h44444444, 0, acc);
      xact(1, 0, B0 + 32'h0, 32'h0, 0, a0);
      xact(1, 0, B0 + 32'h4, 32'h0, 0, a1);
      xact(1, 0, B0 + 32'h8, 32'h0, 0, a2);
      chk("b2b_gap1", 32'(a1 - a0), 32'd2);
      chk("b2b_gap2", 32'(a2 - a1), 32'd2);

      // randomized traffic on both instances
      for (int n = 0; n < 300; n++) begin
         s  = 1'($urandom);
         we = 1'($urandom);
         addr = (s ? B0 : B2) + (32'($urandom_range(0, (s ? D0 : 48) + 3)) << 2);
         if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0) addr = (s ? B0 : B2) - 32'h4;
         xact(s, we, addr, $urandom, int'($urandom_range(0, 3)), acc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
